mux_selfcheck: RTL and testbench

Sequential stimulus-and-check stage that sits directly in front of and behind the 2:1 mux. It drives `mux_a`, `mux_b` and `mux_sel` through all eight input combinations and holds each vector for a growing number of cycles. At the end of each hold window it samples the mux's `mux_out`, compares it against the expected value, and reports pass/fail, an error count and the first failing vector. It gives the project an in-hardware self-test for the mux.

---
 rtl/muxchk_pkg.sv | 16 +
 rtl/muxchk_hold_timer.sv | 34 +++
 rtl/mux_selfcheck.sv | 113 +++++++++++
 tb/tb_mux_selfcheck.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/muxchk_pkg.sv
// Shared types and helpers for the 2:1 mux self-check stage.
package muxchk_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int NUM_VEC = 8;

  function automatic logic mux_expected(input logic a, input logic b, input logic sel);
    return sel ? b : a;
  endfunction

endpackage

// File: rtl/muxchk_hold_timer.sv
// Hold-window timer: load starts a window of len cycles; expire marks its last cycle.
module muxchk_hold_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] len,
  output logic         expire
);

  logic [W-1:0] cnt;
  logic [W-1:0] lim;
  logic         run;

  // A load on the expiring edge chains straight into the next window.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
      lim <= '0;
      run <= 1'b0;
    end else if (load) begin
      cnt <= '0;
      lim <= len - W'(1);
      run <= 1'b1;
    end else if (run) begin
      if (cnt == lim) run <= 1'b0;
      else            cnt <= cnt + W'(1);
    end
  end

  assign expire = run && (cnt == lim);

endmodule

// File: rtl/mux_selfcheck.sv
// In-hardware self-test for a 2:1 mux: drives all 8 vectors, checks mux_out, reports.
// Optional MUXCHK_TRACE_EN adds trace_bits holding the sampled output of every vector.
module mux_selfcheck
  import muxchk_pkg::*;
#(
  parameter int HOLD_BASE = 1,
  parameter int ERR_W     = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             mux_out,
  output logic             mux_a,
  output logic             mux_b,
  output logic             mux_sel,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic             fail_valid,
  output logic [2:0]       fail_vec,
`ifdef MUXCHK_TRACE_EN
  output logic [7:0]       trace_bits,
`endif
  output state_t           state_dbg
);

  localparam int TW = $clog2(HOLD_BASE + NUM_VEC);

  state_t          state;
  state_t          state_next;
  logic [2:0]      vec;
  logic            accept;
  logic            last;
  logic            expire;
  logic            load;
  logic            mismatch;
  logic [TW-1:0]   len;

  assign accept   = (state != DRIVE) && start;
  assign last     = (vec == 3'(NUM_VEC - 1));
  assign mismatch = (mux_out != mux_expected(mux_a, mux_b, mux_sel));
  assign load     = accept || ((state == DRIVE) && expire && !last);
  assign len      = TW'(HOLD_BASE) + TW'(accept ? 3'd0 : vec + 3'd1);

  muxchk_hold_timer #(.W(TW)) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (load),
    .len    (len),
    .expire (expire)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE, DONE: if (start) state_next = DRIVE;
      DRIVE:      if (expire && last) state_next = DONE;
      default:    state_next = IDLE;
    endcase
  end

  // Vector counter, registered mux drive and checker; results of a vector land on its sampling edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vec                       <= 3'd0;
      {mux_a, mux_b, mux_sel}   <= 3'b000;
      err_count                 <= '0;
      fail_valid                <= 1'b0;
      fail_vec                  <= 3'd0;
`ifdef MUXCHK_TRACE_EN
      trace_bits                <= 8'd0;
`endif
    end else if (accept) begin
      vec                       <= 3'd0;
      {mux_a, mux_b, mux_sel}   <= 3'b000;
      err_count                 <= '0;
      fail_valid                <= 1'b0;
      fail_vec                  <= 3'd0;
`ifdef MUXCHK_TRACE_EN
      trace_bits                <= 8'd0;
`endif
    end else if ((state == DRIVE) && expire) begin
      if (mismatch) begin
        if (err_count != {ERR_W{1'b1}}) err_count <= err_count + 1'b1;
        if (!fail_valid) begin
          fail_valid <= 1'b1;
          fail_vec   <= vec;
        end
      end
`ifdef MUXCHK_TRACE_EN
      trace_bits[vec] <= mux_out;
`endif
      if (last) begin
        {mux_a, mux_b, mux_sel} <= 3'b000;
      end else begin
        vec                     <= vec + 3'd1;
        {mux_a, mux_b, mux_sel} <= vec + 3'd1;
      end
    end
  end

  assign busy      = (state == DRIVE);
  assign done      = (state == DONE);
  assign pass      = done && (err_count == '0);
  assign state_dbg = state;

endmodule

// File: tb/tb_mux_selfcheck.sv
// Bench for mux_selfcheck: two instances (HOLD_BASE=1/ERR_W=4, HOLD_BASE=3/ERR_W=2) against fault-injected mux models.
module tb_mux_selfcheck;
  import muxchk_pkg::*;

  // expectation record: busy_len, err, fail_valid, fail_vec, pass, trace
  typedef struct packed {
    logic [7:0] busy_len;
    logic [3:0] err;
    logic       fv;
    logic [2:0] fvec;
    logic       pass;
    logic [7:0] trace;
  } exp_t;
  localparam int EW = $bits(exp_t);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       start1 = 1'b0, start3 = 1'b0;
  logic [7:0] mask1 = 8'd0, mask3 = 8'd0;
  logic       a1, b1, s1, o1, busy1, done1, pass1, fv1;
  logic       a3, b3, s3, o3, busy3, done3, pass3, fv3;
  logic [3:0] err1;
  logic [1:0] err3;
  logic [2:0] fvec1, fvec3;
  state_t     st1, st3;
`ifdef MUXCHK_TRACE_EN
  logic [7:0] tr1, tr3;
`endif

  // mux models: correct behaviour with per-vector inversion faults
  assign o1 = (s1 ? b1 : a1) ^ mask1[{a1, b1, s1}];
  assign o3 = (s3 ? b3 : a3) ^ mask3[{a3, b3, s3}];

  mux_selfcheck #(.HOLD_BASE(1), .ERR_W(4)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .mux_out(o1),
    .mux_a(a1), .mux_b(b1), .mux_sel(s1), .busy(busy1), .done(done1), .pass(pass1),
    .err_count(err1), .fail_valid(fv1), .fail_vec(fvec1),
`ifdef MUXCHK_TRACE_EN
    .trace_bits(tr1),
`endif
    .state_dbg(st1)
  );

  mux_selfcheck #(.HOLD_BASE(3), .ERR_W(2)) dut3 (
    .clk(clk), .rst_n(rst_n), .start(start3), .mux_out(o3),
    .mux_a(a3), .mux_b(b3), .mux_sel(s3), .busy(busy3), .done(done3), .pass(pass3),
    .err_count(err3), .fail_valid(fv3), .fail_vec(fvec3),
`ifdef MUXCHK_TRACE_EN
    .trace_bits(tr3),
`endif
    .state_dbg(st3)
  );

  int total = 0;
  int bad = 0;
  logic [EW-1:0] exp_q1[$];
  logic [EW-1:0] exp_q3[$];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, got, want);
    end
  endtask

  // reference: whole-run outcome from the vector rules
  function automatic logic [EW-1:0] model(input int hb, input int errw, input logic [7:0] mask);
    exp_t e;
    int errs, sat, a, b, s, good, got;
    e = '0;
    errs = 0;
    e.busy_len = 8'(8 * hb + 28);
    for (int v = 0; v < 8; v++) begin
      a = (v >> 2) & 1; b = (v >> 1) & 1; s = v & 1;
      good = s ? b : a;
      got = good ^ int'(mask[v]);
      e.trace[v] = got[0];
      if (got != good) begin
        if (errs == 0) e.fvec = 3'(v);
        errs++;
      end
    end
    sat = (1 << errw) - 1;
    e.err = 4'(errs > sat ? sat : errs);
    e.fv = (errs > 0);
    e.pass = (errs == 0);
    return e;
  endfunction

  // which vector should be on the outputs in busy cycle k (1-based)
  function automatic int vec_at(input int hb, input int k);
    int acc = 0;
    for (int v = 0; v < 8; v++) begin
      acc += hb + v;
      if (k <= acc) return v;
    end
    return 8;
  endfunction

  // monitors
  int bcnt1 = 0, bcnt3 = 0;
  logic dq1 = 1'b0, dq3 = 1'b0;

  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (busy1) begin
        bcnt1++;
        chk("vec1", {29'd0, a1, b1, s1}, 32'(vec_at(1, bcnt1)));
      end else begin
        chk("idle_mux1", {29'd0, a1, b1, s1}, 32'd0);
      end
      if (done1 && !dq1) begin
        if (exp_q1.size() == 0) begin
          chk("spurious_done1", 32'd1, 32'd0);
        end else begin
          e = exp_t'(exp_q1.pop_front());
          chk("busy_len1", 32'(bcnt1), 32'(e.busy_len));
          chk("err1", 32'(err1), 32'(e.err));
          chk("fail_valid1", 32'(fv1), 32'(e.fv));
          if (e.fv) chk("fail_vec1", 32'(fvec1), 32'(e.fvec));
          chk("pass1", 32'(pass1), 32'(e.pass));
`ifdef MUXCHK_TRACE_EN
          chk("trace1", 32'(tr1), 32'(e.trace));
`endif
        end
      end
      if (!busy1) bcnt1 = 0;
      dq1 = done1;
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (busy3) begin
        bcnt3++;
        chk("vec3", {29'd0, a3, b3, s3}, 32'(vec_at(3, bcnt3)));
      end
      if (done3 && !dq3) begin
        if (exp_q3.size() == 0) begin
          chk("spurious_done3", 32'd1, 32'd0);
        end else begin
          e = exp_t'(exp_q3.pop_front());
          chk("busy_len3", 32'(bcnt3), 32'(e.busy_len));
          chk("err3", 32'(err3), 32'(e.err));
          chk("fail_valid3", 32'(fv3), 32'(e.fv));
          if (e.fv) chk("fail_vec3", 32'(fvec3), 32'(e.fvec));
          chk("pass3", 32'(pass3), 32'(e.pass));
`ifdef MUXCHK_TRACE_EN
          chk("trace3", 32'(tr3), 32'(e.trace));
`endif
        end
      end
      if (!busy3) bcnt3 = 0;
      dq3 = done3;
    end
  end

  // driver tasks
  task automatic run1(input logic [7:0] m);
    mask1 = m;
    exp_q1.push_back(model(1, 4, m));
    @(negedge clk) start1 = 1'b1;
    @(negedge clk) start1 = 1'b0;
  endtask

  task automatic run3(input logic [7:0] m);
    mask3 = m;
    exp_q3.push_back(model(3, 2, m));
    @(negedge clk) start3 = 1'b1;
    @(negedge clk) start3 = 1'b0;
  endtask

  task automatic wait_idle();
    int i;
    for (i = 0; i < 3000; i++) begin
      if (exp_q1.size() == 0 && exp_q3.size() == 0 && !busy1 && !busy3) break;
      @(negedge clk);
    end
    if (i >= 3000) begin
      chk("timeout", 32'd1, 32'd0);
      exp_q1.delete();
      exp_q3.delete();
    end
    @(negedge clk);
  endtask

  task automatic chk_reset1(input string tag);
    chk({tag, "_busy"}, 32'(busy1), 32'd0);
    chk({tag, "_done"}, 32'(done1), 32'd0);
    chk({tag, "_pass"}, 32'(pass1), 32'd0);
    chk({tag, "_err"}, 32'(err1), 32'd0);
    chk({tag, "_fv"}, {28'd0, fv1, fvec1}, 32'd0);
    chk({tag, "_mux"}, {29'd0, a1, b1, s1}, 32'd0);
    chk({tag, "_state"}, 32'(st1), 32'(IDLE));
`ifdef MUXCHK_TRACE_EN
    chk({tag, "_trace"}, 32'(tr1), 32'd0);
`endif
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset1("rst1");
    chk("rst3_state", {27'd0, busy3, done3, pass3, 2'(st3)}, 32'(IDLE));
    rst_n = 1'b1;
    @(negedge clk);

    run1(8'h00);              // correct mux
    wait_idle();
    run1(8'b1101_1000);       // stuck at 0
    wait_idle();
    run1(8'b0011_1100);       // swapped inputs
    wait_idle();
    run3(8'h00);              // long holds, correct mux
    wait_idle();
    run3(8'hFF);              // every vector wrong: err saturates at 3
    wait_idle();

    // start re-pulsed at busy cycle 10 must be ignored
    run1(8'h00);
    repeat (9) @(negedge clk);
    start1 = 1'b1;
    @(negedge clk) start1 = 1'b0;
    wait_idle();

    // reset during vector 4 aborts the run
    run1(8'($urandom_range(0, 255)));
    repeat (11) @(negedge clk);
    chk("pre_abort_busy", {30'd0, busy1, a1}, 32'd3);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    void'(exp_q1.pop_back());
    chk_reset1("abort1");
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("abort_no_done", 32'(done1), 32'd0);
    run1(8'h00);
    wait_idle();

    // randomized fault patterns on both instances, overlapping runs
    for (int i = 0; i < 8; i++) begin
      if ($urandom_range(0, 1) == 0) run1(8'($urandom_range(0, 255)));
      else                           run3(8'($urandom_range(0, 255)));
      if ($urandom_range(0, 1) == 0) begin
        if (!busy1 && exp_q1.size() == 0) run1(8'($urandom_range(0, 255)));
      end
      wait_idle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
